// File: rtl/cache_ram_arbiter.sv
// Clears the 128 x 64 cache line RAM after reset/flush, then shares its single port between core (A) and refill (B).
// Define RAM_ARB_FIXED_PRIO_EN to give B fixed priority over A instead of round-robin arbitration.
module cache_ram_arbiter #(
    parameter int ENTRIES = 128,
    parameter int INDEX_W = 7,
    parameter int DATA_W  = 64
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush_req,
    output logic               init_done,

    input  logic               a_req,
    input  logic               a_we,
    input  logic [INDEX_W-1:0] a_index,
    input  logic [DATA_W-1:0]  a_wmask,
    input  logic [DATA_W-1:0]  a_wdata,
    output logic               a_gnt,
    output logic               a_rvalid,
    output logic [DATA_W-1:0]  a_rdata,

    input  logic               b_req,
    input  logic               b_we,
    input  logic [INDEX_W-1:0] b_index,
    input  logic [DATA_W-1:0]  b_wmask,
    input  logic [DATA_W-1:0]  b_wdata,
    output logic               b_gnt,
    output logic               b_rvalid,
    output logic [DATA_W-1:0]  b_rdata,

    output logic [INDEX_W-1:0] ram_index,
    output logic               ram_wen,
    output logic [DATA_W-1:0]  ram_wmask,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [INDEX_W-1:0] clr_cnt;
    logic [INDEX_W-1:0] idx_hold;
    logic               clr_last;
    logic               idle_ok;

    assign clr_last  = (clr_cnt == INDEX_W'(ENTRIES - 1));
    assign idle_ok   = (state == IDLE) && !flush_req;
    assign init_done = (state == IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_last) state_next = IDLE;
            IDLE:    if (flush_req) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
        end else begin
            clr_cnt <= '0;
        end
    end

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign b_gnt = idle_ok & b_req;
    assign a_gnt = idle_ok & a_req & ~b_req;
`else
    // last_b = 1 means B was granted most recently, so A wins the next conflict
    logic last_b;

    assign a_gnt = idle_ok & a_req & (~b_req | last_b);
    assign b_gnt = idle_ok & b_req & (~a_req | ~last_b);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_b <= 1'b1;
        end else if (a_gnt | b_gnt) begin
            last_b <= b_gnt;
        end
    end
`endif

    always_comb begin
        ram_index = idx_hold;
        ram_wen   = 1'b0;
        ram_wmask = '0;
        ram_wdata = '0;
        if (state == CLEAR) begin
            ram_index = clr_cnt;
            ram_wen   = 1'b1;
            ram_wmask = '1;
        end else if (a_gnt) begin
            ram_index = a_index;
            ram_wen   = a_we;
            ram_wmask = a_wmask;
            ram_wdata = a_wdata;
        end else if (b_gnt) begin
            ram_index = b_index;
            ram_wen   = b_we;
            ram_wmask = b_wmask;
            ram_wdata = b_wdata;
        end
    end

    // Idle cycles keep the last index on the RAM so its address lines stay quiet
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_hold <= '0;
        end else begin
            idx_hold <= ram_index;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (a_gnt && !a_we) a_rdata <= ram_rdata;
            if (b_gnt && !b_we) b_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// Self-checking bench for cache_ram_arbiter: behavioural RAM, reference memory model and randomized traffic.
// Honours RAM_ARB_FIXED_PRIO_EN the same way the design does.
module tb_cache_ram_arbiter;

    localparam int ENTRIES = 128;
    localparam int INDEX_W = 7;
    localparam int DATA_W  = 64;

    logic               clk;
    logic               rstn;
    logic               flush_req;
    logic               init_done;
    logic               a_req, a_we, b_req, b_we;
    logic [INDEX_W-1:0] a_index, b_index;
    logic [DATA_W-1:0]  a_wmask, a_wdata, b_wmask, b_wdata;
    logic               a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DATA_W-1:0]  a_rdata, b_rdata;
    logic [INDEX_W-1:0] ram_index;
    logic               ram_wen;
    logic [DATA_W-1:0]  ram_wmask, ram_wdata, ram_rdata;

    logic [DATA_W-1:0]  ram_mem [ENTRIES];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [DATA_W-1:0]  model_mem [ENTRIES];
    logic               model_last_b;
    logic [DATA_W-1:0]  exp_a_rdata, exp_b_rdata;
    logic               exp_a_rvalid, exp_b_rvalid;
    logic [INDEX_W-1:0] exp_hold;

    cache_ram_arbiter #(
        .ENTRIES(ENTRIES),
        .INDEX_W(INDEX_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .flush_req(flush_req),
        .init_done(init_done),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_index  (a_index),
        .a_wmask  (a_wmask),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_index  (b_index),
        .b_wmask  (b_wmask),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .ram_index(ram_index),
        .ram_wen  (ram_wen),
        .ram_wmask(ram_wmask),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-masked RAM: write lands at the edge, read is combinational
    always @(posedge clk) begin
        if (ram_wen) ram_mem[ram_index] <= (ram_mem[ram_index] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
    assign ram_rdata = ram_mem[ram_index];

    task automatic drive_idle();
        flush_req = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_index = '0; a_wmask = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_index = '0; b_wmask = '0; b_wdata = '0;
    endtask

    task automatic set_a(input logic we, input logic [INDEX_W-1:0] idx, input logic [DATA_W-1:0] mask, input logic [DATA_W-1:0] data);
        a_req = 1'b1; a_we = we; a_index = idx; a_wmask = mask; a_wdata = data;
    endtask

    task automatic set_b(input logic we, input logic [INDEX_W-1:0] idx, input logic [DATA_W-1:0] mask, input logic [DATA_W-1:0] data);
        b_req = 1'b1; b_we = we; b_index = idx; b_wmask = mask; b_wdata = data;
    endtask

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) model_mem[i] = '0;
        exp_hold     = INDEX_W'(ENTRIES - 1);
        exp_a_rvalid = 1'b0;
        exp_b_rvalid = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        model_last_b = 1'b1;
        exp_a_rdata  = '0;
        exp_b_rdata  = '0;
    endtask

    // Who should own the port this cycle, given the current requests (IDLE only)
    function automatic void predict(output logic ga, output logic gb);
        ga = 1'b0;
        gb = 1'b0;
        if (!flush_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            gb = b_req;
            ga = a_req && !b_req;
`else
            if (a_req && b_req) begin
                ga = model_last_b;
                gb = !model_last_b;
            end else begin
                ga = a_req;
                gb = b_req;
            end
`endif
        end
    endfunction

    // Apply the effect of this cycle's grants to the reference model
    task automatic commit(input logic ga, input logic gb);
        exp_a_rvalid = 1'b0;
        exp_b_rvalid = 1'b0;
        if (ga) begin
            if (a_we) model_mem[a_index] = (model_mem[a_index] & ~a_wmask) | (a_wdata & a_wmask);
            else begin
                exp_a_rdata  = model_mem[a_index];
                exp_a_rvalid = 1'b1;
            end
            exp_hold     = a_index;
            model_last_b = 1'b0;
        end
        if (gb) begin
            if (b_we) model_mem[b_index] = (model_mem[b_index] & ~b_wmask) | (b_wdata & b_wmask);
            else begin
                exp_b_rdata  = model_mem[b_index];
                exp_b_rvalid = 1'b1;
            end
            exp_hold     = b_index;
            model_last_b = 1'b1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive_idle();
        a_req = 1'b1;
        #1;
        n_checks++;
        if ({init_done, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wen, ram_index} !== {6'b000001, 7'd0})
            $display("[TB] FAIL reset_ctrl: got %b expected %b", {init_done, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wen, ram_index}, {6'b000001, 7'd0});
        else n_pass++;
        n_checks++;
        if ({a_rdata, b_rdata, ram_wmask, ram_wdata} !== {64'd0, 64'd0, {64{1'b1}}, 64'd0})
            $display("[TB] FAIL reset_data: got %h %h %h %h expected 0 0 all-ones 0", a_rdata, b_rdata, ram_wmask, ram_wdata);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            flush_req = (i == ENTRIES - 1);
            #1;
            n_checks++;
            if ({ram_wen, ram_index, ram_wmask, ram_wdata, init_done, a_gnt} !== {1'b1, 7'(i), {64{1'b1}}, 64'd0, 1'b0, 1'b0})
                $display("[TB] FAIL clear_step %0d: got wen=%b idx=%0d mask=%h data=%h done=%b gnt=%b", i, ram_wen, ram_index, ram_wmask, ram_wdata, init_done, a_gnt);
            else n_pass++;
            @(negedge clk);
        end
        drive_idle();
        #1;
        n_checks++;
        if ({init_done, ram_wen, ram_index} !== {1'b1, 1'b0, 7'd127})
            $display("[TB] FAIL clear_done: got done=%b wen=%b idx=%0d expected 1 0 127", init_done, ram_wen, ram_index);
        else n_pass++;
        commit(1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_read_after_clear();
        logic ga, gb;
        set_a(1'b0, 7'd5, '0, '0);
        predict(ga, gb);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, ram_wen, ram_index} !== {3'b100, 7'd5})
            $display("[TB] FAIL read5_grant: got %b expected %b", {a_gnt, b_gnt, ram_wen, ram_index}, {3'b100, 7'd5});
        else n_pass++;
        commit(ga, gb);
        @(negedge clk);
        drive_idle();
        n_checks++;
        if ({a_rvalid, b_rvalid, a_rdata} !== {2'b10, 64'd0})
            $display("[TB] FAIL read5_data: got rvalid=%b/%b rdata=%h expected 1/0 0", a_rvalid, b_rvalid, a_rdata);
        else n_pass++;
        #1;
        commit(1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({a_rvalid, a_rdata} !== {1'b0, 64'd0})
            $display("[TB] FAIL read5_one_shot: got rvalid=%b rdata=%h expected 0 0", a_rvalid, a_rdata);
        else n_pass++;
    endtask

    task automatic test_masked_write();
        logic ga, gb;
        set_a(1'b1, 7'd3, 64'h0000_0000_FFFF_FFFF, 64'h1111_2222_3333_4444);
        predict(ga, gb);
        #1;
        n_checks++;
        if ({a_gnt, ram_wen, ram_index, ram_wmask, ram_wdata} !== {2'b11, 7'd3, 64'h0000_0000_FFFF_FFFF, 64'h1111_2222_3333_4444})
            $display("[TB] FAIL mwrite_port: got gnt=%b wen=%b idx=%0d mask=%h data=%h", a_gnt, ram_wen, ram_index, ram_wmask, ram_wdata);
        else n_pass++;
        commit(ga, gb);
        @(negedge clk);
        set_a(1'b0, 7'd3, '0, '0);
        predict(ga, gb);
        #1;
        commit(ga, gb);
        @(negedge clk);
        drive_idle();
        n_checks++;
        if ({a_rvalid, a_rdata} !== {1'b1, 64'h0000_0000_3333_4444})
            $display("[TB] FAIL mwrite_readback: got rvalid=%b rdata=%h expected 1 0000000033334444", a_rvalid, a_rdata);
        else n_pass++;
        #1;
        commit(1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_pair;
        set_a(1'b0, 7'd10, '0, '0);
        set_b(1'b0, 7'd11, '0, '0);
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_pair = 2'b01;
`else
        exp_pair = model_last_b ? 2'b10 : 2'b01;
`endif
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if ({a_gnt, b_gnt} !== exp_pair)
                $display("[TB] FAIL contention_%0d: got a/b gnt=%b expected %b", k, {a_gnt, b_gnt}, exp_pair);
            else n_pass++;
            commit(exp_pair[1], exp_pair[0]);
            @(negedge clk);
            n_checks++;
            if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== {exp_a_rvalid, exp_b_rvalid, exp_a_rdata, exp_b_rdata})
                $display("[TB] FAIL contention_rd_%0d: got %b%b %h %h expected %b%b %h %h", k, a_rvalid, b_rvalid, a_rdata, b_rdata, exp_a_rvalid, exp_b_rvalid, exp_a_rdata, exp_b_rdata);
            else n_pass++;
`ifndef RAM_ARB_FIXED_PRIO_EN
            exp_pair = ~exp_pair;
`endif
        end
        drive_idle();
        #1;
        commit(1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic ga, gb;
        set_b(1'b1, 7'd127, {64{1'b1}}, 64'hDEAD_BEEF_0000_0001);
        predict(ga, gb);
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, ram_wen, ram_index} !== {3'b011, 7'd127})
            $display("[TB] FAIL raw_write: got %b expected %b", {a_gnt, b_gnt, ram_wen, ram_index}, {3'b011, 7'd127});
        else n_pass++;
        commit(ga, gb);
        @(negedge clk);
        drive_idle();
        set_a(1'b0, 7'd127, '0, '0);
        predict(ga, gb);
        #1;
        commit(ga, gb);
        @(negedge clk);
        drive_idle();
        n_checks++;
        if ({a_rvalid, a_rdata} !== {1'b1, 64'hDEAD_BEEF_0000_0001})
            $display("[TB] FAIL raw_read: got rvalid=%b rdata=%h expected 1 deadbeef00000001", a_rvalid, a_rdata);
        else n_pass++;
        #1;
        commit(1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic pa, pb, ga, gb;
        pa = 1'b0;
        pb = 1'b0;
        drive_idle();
        for (int c = 0; c < 400; c++) begin
            if (!pa && $urandom_range(0, 1) == 1) begin
                pa = 1'b1;
                set_a(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
            end
            if (!pb && $urandom_range(0, 1) == 1) begin
                pb = 1'b1;
                set_b(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
            end
            a_req = pa;
            b_req = pb;
            predict(ga, gb);
            #1;
            n_checks++;
            if ({a_gnt, b_gnt, ram_wen, ram_index} !== {ga, gb, (ga ? a_we : (gb ? b_we : 1'b0)), (ga ? a_index : (gb ? b_index : exp_hold))})
                $display("[TB] FAIL rand_port %0d: got gnt=%b%b wen=%b idx=%0d expected gnt=%b%b", c, a_gnt, b_gnt, ram_wen, ram_index, ga, gb);
            else n_pass++;
            commit(ga, gb);
            @(negedge clk);
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
            n_checks++;
            if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== {exp_a_rvalid, exp_b_rvalid, exp_a_rdata, exp_b_rdata})
                $display("[TB] FAIL rand_read %0d: got %b%b %h %h expected %b%b %h %h", c, a_rvalid, b_rvalid, a_rdata, b_rdata, exp_a_rvalid, exp_b_rvalid, exp_a_rdata, exp_b_rdata);
            else n_pass++;
        end
        drive_idle();
        #1;
        commit(1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic ga, gb;
        set_a(1'b0, 7'd127, '0, '0);
        flush_req = 1'b1;
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, ram_wen, init_done} !== 4'b0001)
            $display("[TB] FAIL flush_cycle: got gnt=%b%b wen=%b done=%b expected 00 0 1", a_gnt, b_gnt, ram_wen, init_done);
        else n_pass++;
        commit(1'b0, 1'b0);
        @(negedge clk);
        drive_idle();
        for (int i = 0; i < ENTRIES; i++) begin
            #1;
            n_checks++;
            if ({ram_wen, ram_index, init_done} !== {1'b1, 7'(i), 1'b0})
                $display("[TB] FAIL flush_clear %0d: got wen=%b idx=%0d done=%b", i, ram_wen, ram_index, init_done);
            else n_pass++;
            @(negedge clk);
        end
        model_clear();
        set_a(1'b0, 7'd127, '0, '0);
        predict(ga, gb);
        #1;
        commit(ga, gb);
        @(negedge clk);
        drive_idle();
        n_checks++;
        if ({a_rvalid, a_rdata} !== {1'b1, 64'd0})
            $display("[TB] FAIL flush_readback: got rvalid=%b rdata=%h expected 1 0", a_rvalid, a_rdata);
        else n_pass++;
        #1;
        commit(1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        set_a(1'b0, 7'd6, '0, '0);
        #1;
        @(negedge clk);
        drive_idle();
        n_checks++;
        if (a_rvalid !== 1'b1)
            $display("[TB] FAIL midacc_rvalid: got %b expected 1", a_rvalid);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({a_rvalid, a_rdata, ram_wen, ram_index, init_done} !== {1'b0, 64'd0, 1'b1, 7'd0, 1'b0})
            $display("[TB] FAIL midacc_reset: got rvalid=%b rdata=%h wen=%b idx=%0d done=%b", a_rvalid, a_rdata, ram_wen, ram_index, init_done);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        for (int i = 0; i < 60; i++) @(negedge clk);
        #1;
        n_checks++;
        if (ram_index !== 7'd60)
            $display("[TB] FAIL midclr_pos: got idx=%0d expected 60", ram_index);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({ram_index, init_done} !== {7'd0, 1'b0})
            $display("[TB] FAIL midclr_reset: got idx=%0d done=%b expected 0 0", ram_index, init_done);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < ENTRIES; i++) begin
            #1;
            n_checks++;
            if ({ram_index, init_done} !== {7'(i), 1'b0})
                $display("[TB] FAIL midclr_restart %0d: got idx=%0d done=%b", i, ram_index, init_done);
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (init_done !== 1'b1)
            $display("[TB] FAIL midclr_done: got %b expected 1", init_done);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_read_after_clear();
        test_masked_write();
        test_round_robin();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
